mux_salida: RTL and testbench

Output-bus multiplexer for the RTC interface path. It selects either the 8-bit register address (`direccion`) or the 8-bit data byte (`dato`) and drives the result onto the shared 8-bit output bus (`salida_bus`). The block sits between the RTC control FSM, which supplies `seleccion` and `habilitar`, and the bus driver to the RTC chip. The output is registered so the bus is glitch-free and changes only on a clock edge.

---
 rtl/mux_salida.sv | 45 ++++
 tb/tb_mux_salida.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mux_salida.sv
// Registered 2:1 output-bus multiplexer for the RTC interface path.
// Drives either the register address or the data byte onto the shared bus, glitch-free.
module mux_salida (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] direccion,
  input  logic [7:0] dato,
  input  logic       seleccion,
  input  logic       habilitar,
  output logic [7:0] salida_bus,
  output logic       fuente_dir
);

  logic [7:0] fuente_sel_s;
  logic [7:0] salida_bus_r;
  logic       fuente_dir_r;

  // Pick the source byte that will be loaded on the next enabled edge.
  always_comb begin
    fuente_sel_s = 8'h00;
    if (seleccion == 1'b1) begin
      fuente_sel_s = direccion;
    end else begin
      fuente_sel_s = dato;
    end
  end

  // Output registers; reset clears the bus asynchronously and outranks the enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      salida_bus_r <= 8'h00;
      fuente_dir_r <= 1'b0;
    end else if (habilitar) begin
      salida_bus_r <= fuente_sel_s;
      fuente_dir_r <= seleccion;
    end else begin
      salida_bus_r <= salida_bus_r;
      fuente_dir_r <= fuente_dir_r;
    end
  end

  assign salida_bus = salida_bus_r;
  assign fuente_dir = fuente_dir_r;

endmodule

// File: tb/tb_mux_salida.sv
// Self-checking bench for mux_salida: directed vectors, a per-cycle compare
// against a behavioural expectation, and literal pins on key values.
module tb_mux_salida;

  logic       clk;
  logic       reset;
  logic [7:0] direccion;
  logic [7:0] dato;
  logic       seleccion;
  logic       habilitar;
  logic [7:0] salida_bus;
  logic       fuente_dir;

  logic [7:0] exp_bus;
  logic       exp_fd;
  int         checks;
  int         errors;

  mux_salida dut (
    .clk        (clk),
    .reset      (reset),
    .direccion  (direccion),
    .dato       (dato),
    .seleccion  (seleccion),
    .habilitar  (habilitar),
    .salida_bus (salida_bus),
    .fuente_dir (fuente_dir)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Every falling edge: outputs must equal what the bus contents should be by now.
  always @(negedge clk) begin
    checks = checks + 1;
    if (salida_bus !== exp_bus || fuente_dir !== exp_fd) begin
      errors = errors + 1;
      $display("FAIL cycle_compare t=%0t: got bus=%h fd=%b, want bus=%h fd=%b",
               $time, salida_bus, fuente_dir, exp_bus, exp_fd);
    end
  end

  task automatic check_lit(input string name, input logic [7:0] bus_w, input logic fd_w);
    checks = checks + 1;
    if (salida_bus !== bus_w || fuente_dir !== fd_w) begin
      errors = errors + 1;
      $display("FAIL %s: got bus=%h fd=%b, want bus=%h fd=%b",
               name, salida_bus, fuente_dir, bus_w, fd_w);
    end
  endtask

  // Present one input vector for one clock; the bus should show the chosen byte
  // afterwards if enabled (and out of reset), otherwise keep what it had.
  task automatic apply(input logic [7:0] d, input logic [7:0] t,
                       input logic s, input logic h);
    logic [7:0] nxt_bus;
    logic       nxt_fd;
    direccion = d;
    dato      = t;
    seleccion = s;
    habilitar = h;
    if (reset) begin
      nxt_bus = 8'h00;
      nxt_fd  = 1'b0;
    end else if (h) begin
      nxt_bus = s ? d : t;
      nxt_fd  = s;
    end else begin
      nxt_bus = exp_bus;
      nxt_fd  = exp_fd;
    end
    @(posedge clk);
    exp_bus = nxt_bus;
    exp_fd  = nxt_fd;
    @(negedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_bus   = 8'h00;
    exp_fd    = 1'b0;
    reset     = 1'b1;
    direccion = 8'hFF;
    dato      = 8'hAA;
    seleccion = 1'b1;
    habilitar = 1'b1;
    #1;
    check_lit("reset_immediate", 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    check_lit("reset_held", 8'h00, 1'b0);
    reset = 1'b0;

    // Alternating select.
    apply(8'hFF, 8'hAA, 1'b1, 1'b1);
    check_lit("alt_1", 8'hFF, 1'b1);
    apply(8'hFF, 8'hAA, 1'b0, 1'b1);
    check_lit("alt_0", 8'hAA, 1'b0);
    apply(8'hFF, 8'hAA, 1'b1, 1'b1);
    apply(8'hFF, 8'hAA, 1'b0, 1'b1);
    check_lit("alt_last", 8'hAA, 1'b0);

    // Unselected source changes.
    apply(8'hFF, 8'h22, 1'b0, 1'b1);
    check_lit("dato_22", 8'h22, 1'b0);
    apply(8'h33, 8'h22, 1'b0, 1'b1);
    check_lit("unsel_dir", 8'h22, 1'b0);
    apply(8'h33, 8'h22, 1'b1, 1'b1);
    check_lit("sel_dir_33", 8'h33, 1'b1);
    apply(8'h33, 8'h22, 1'b0, 1'b1);
    check_lit("sel_dato_22", 8'h22, 1'b0);

    // Hold with enable low while everything else churns.
    apply(8'h33, 8'h22, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      apply(8'h40 + 8'(i), 8'h90 - 8'(i), 1'(i), 1'b0);
    end
    check_lit("hold_5", 8'h33, 1'b1);

    // Mid-operation reset between edges.
    apply(8'h5A, 8'hC3, 1'b1, 1'b1);
    apply(8'h5A, 8'hC3, 1'b0, 1'b1);
    #2;
    reset   = 1'b1;
    exp_bus = 8'h00;
    exp_fd  = 1'b0;
    #1;
    check_lit("mid_reset_async", 8'h00, 1'b0);
    apply(8'h5A, 8'hC3, 1'b1, 1'b1);
    check_lit("reset_beats_enable", 8'h00, 1'b0);
    reset = 1'b0;
    apply(8'h5A, 8'hC3, 1'b1, 1'b1);
    check_lit("post_reset_load", 8'h5A, 1'b1);

    // Exhaustive byte sweep on both selections.
    for (int i = 0; i < 256; i++) begin
      apply(8'(i), ~8'(i), 1'b1, 1'b1);
      apply(8'(i), ~8'(i), 1'b0, 1'b1);
    end
    check_lit("sweep_end", 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
